// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD power sequencer: state encoding, default
// delays and the per-state panel output table.
package lcd_seq_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_PRST      = 3'd3,
      ST_DISP_WAIT = 3'd4,
      ST_RUN       = 3'd5,
      ST_PWR_DOWN  = 3'd6
   } lcd_state_e;

   localparam int unsigned DEF_LOCK_STABLE = 1024;
   localparam int unsigned DEF_PANEL_RST   = 192;
   localparam int unsigned DEF_DISP_DELAY  = 64;
   localparam int unsigned DEF_BL_DELAY    = 4096;
   localparam int unsigned DEF_OFF_DELAY   = 1024;
   localparam int unsigned DEF_CNT_W       = 20;

   typedef struct packed {
      logic pix_rstn;
      logic lcd_rstn;
      logic lcd_disp;
      logic backlight;
      logic ready;
   } lcd_out_t;

   // Panel pin levels for a state; bl_on only matters in RUN.
   function automatic lcd_out_t state_outputs(input lcd_state_e st, input logic bl_on);
      lcd_out_t o;
      o = '{pix_rstn: 1'b0, lcd_rstn: 1'b0, lcd_disp: 1'b0, backlight: 1'b0, ready: 1'b0};
      case (st)
         ST_DISP_WAIT: begin
            o.lcd_rstn = 1'b1;
            o.lcd_disp = 1'b1;
         end
         ST_RUN: begin
            o.pix_rstn  = 1'b1;
            o.lcd_rstn  = 1'b1;
            o.lcd_disp  = 1'b1;
            o.backlight = bl_on;
            o.ready     = 1'b1;
         end
         ST_PWR_DOWN: begin
            o.pix_rstn = 1'b1;
            o.lcd_rstn = 1'b1;
            o.lcd_disp = 1'b1;
         end
         default: begin
            o.pix_rstn = 1'b0;
         end
      endcase
      return o;
   endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser for an asynchronous level input, synchronous
// active-low reset. Reusable for any slow async LCD control input.
module lock_sync (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the async input.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/lcd_power_sequencer.sv
// LCD panel power sequencer: waits for a stable pixel PLL lock, then brings the
// panel, pixel pipeline and backlight up in order and tears them down safely.
module lcd_power_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
   parameter int unsigned PANEL_RST   = DEF_PANEL_RST,
   parameter int unsigned DISP_DELAY  = DEF_DISP_DELAY,
   parameter int unsigned BL_DELAY    = DEF_BL_DELAY,
   parameter int unsigned OFF_DELAY   = DEF_OFF_DELAY,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       locked,
   input  logic       enable,
   output logic       pix_rstn,
   output logic       lcd_rstn,
   output logic       lcd_disp,
   output logic       backlight,
   output logic       ready,
   output logic [2:0] state,
   output logic [7:0] lock_loss_count
);

   logic             locked_s;
   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       llc_q, llc_d;
   lcd_out_t         out_q, out_d;
   logic             bl_d;

   // Counter load is delay-1 so that a state with delay N lasts exactly N cycles.
   function automatic logic [CNT_W-1:0] load_value(input lcd_state_e st);
      logic [CNT_W-1:0] v;
      case (st)
         ST_SETTLE:    v = CNT_W'(LOCK_STABLE - 32'd1);
         ST_PRST:      v = CNT_W'(PANEL_RST - 32'd1);
         ST_DISP_WAIT: v = CNT_W'(DISP_DELAY - 32'd1);
         ST_RUN:       v = CNT_W'(BL_DELAY - 32'd1);
         ST_PWR_DOWN:  v = CNT_W'(OFF_DELAY - 32'd1);
         default:      v = {CNT_W{1'b0}};
      endcase
      return v;
   endfunction

   lock_sync u_lock_sync (
      .clk_i  (clock),
      .rstn_i (resetn),
      .d_i    (locked),
      .q_o    (locked_s)
   );

   logic cnt_done_s;
   assign cnt_done_s = (cnt_q == {CNT_W{1'b0}});

   // Next-state decision; lock loss always outranks enable.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF: begin
            if (enable) state_d = ST_WAIT_LOCK;
            else        state_d = ST_OFF;
         end
         ST_WAIT_LOCK: begin
            if (!enable)       state_d = ST_OFF;
            else if (locked_s) state_d = ST_SETTLE;
            else               state_d = ST_WAIT_LOCK;
         end
         ST_SETTLE: begin
            if (!locked_s)       state_d = ST_WAIT_LOCK;
            else if (!enable)    state_d = ST_OFF;
            else if (cnt_done_s) state_d = ST_PRST;
            else                 state_d = ST_SETTLE;
         end
         ST_PRST: begin
            if (!locked_s)       state_d = ST_WAIT_LOCK;
            else if (!enable)    state_d = ST_OFF;
            else if (cnt_done_s) state_d = ST_DISP_WAIT;
            else                 state_d = ST_PRST;
         end
         ST_DISP_WAIT: begin
            if (!locked_s)       state_d = ST_WAIT_LOCK;
            else if (!enable)    state_d = ST_OFF;
            else if (cnt_done_s) state_d = ST_RUN;
            else                 state_d = ST_DISP_WAIT;
         end
         ST_RUN: begin
            if (!locked_s)    state_d = ST_WAIT_LOCK;
            else if (!enable) state_d = ST_PWR_DOWN;
            else              state_d = ST_RUN;
         end
         ST_PWR_DOWN: begin
            // Lock gone while shutting down: nothing left worth sequencing.
            if (!locked_s)       state_d = ST_OFF;
            else if (cnt_done_s) state_d = ST_OFF;
            else                 state_d = ST_PWR_DOWN;
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase
   end

   // Shared delay counter, reloaded on every state change, then holds at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = load_value(state_d);
      end else if (!cnt_done_s) begin
         cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Backlight, registered outputs and lock-loss tally derived from the next state.
   always_comb begin
      bl_d  = (state_q == ST_RUN) && (state_d == ST_RUN) && cnt_done_s;
      out_d = state_outputs(state_d, bl_d);
      llc_d = llc_q;
      if ((state_q == ST_RUN) && !locked_s && (llc_q != 8'hFF)) begin
         llc_d = llc_q + 8'd1;
      end else begin
         llc_d = llc_q;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= ST_OFF;
         cnt_q   <= {CNT_W{1'b0}};
         llc_q   <= 8'd0;
         out_q   <= '{pix_rstn: 1'b0, lcd_rstn: 1'b0, lcd_disp: 1'b0, backlight: 1'b0, ready: 1'b0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         llc_q   <= llc_d;
         out_q   <= out_d;
      end
   end

   assign pix_rstn        = out_q.pix_rstn;
   assign lcd_rstn        = out_q.lcd_rstn;
   assign lcd_disp        = out_q.lcd_disp;
   assign backlight       = out_q.backlight;
   assign ready           = out_q.ready;
   assign state           = state_q;
   assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Bench for lcd_power_sequencer: directed scenarios with literal expectations,
// then random stimulus, all checked each cycle against a timestamp-based model.
module tb_lcd_power_sequencer;

   localparam int LS = 8;
   localparam int PR = 4;
   localparam int DD = 3;
   localparam int BL = 5;
   localparam int OD = 2;

   logic       clock;
   logic       resetn;
   logic       locked;
   logic       enable;
   logic       pix_rstn, lcd_rstn, lcd_disp, backlight, ready;
   logic [2:0] state;
   logic [7:0] lock_loss_count;

   int checks = 0;
   int errors = 0;

   // Model: phase number, cycles spent in phase, lock history, loss tally.
   int m_phase = 0;
   int m_t     = 0;
   int m_llc   = 0;
   bit m_ls_a  = 1'b0;
   bit m_ls_b  = 1'b0;

   lcd_power_sequencer #(
      .LOCK_STABLE (LS),
      .PANEL_RST   (PR),
      .DISP_DELAY  (DD),
      .BL_DELAY    (BL),
      .OFF_DELAY   (OD),
      .CNT_W       (20)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .locked          (locked),
      .enable          (enable),
      .pix_rstn        (pix_rstn),
      .lcd_rstn        (lcd_rstn),
      .lcd_disp        (lcd_disp),
      .backlight       (backlight),
      .ready           (ready),
      .state           (state),
      .lock_loss_count (lock_loss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int dur(input int ph);
      case (ph)
         2:       return LS;
         3:       return PR;
         4:       return DD;
         6:       return OD;
         default: return 1;
      endcase
   endfunction

   function automatic logic [15:0] model_vec();
      logic [4:0] o;  // pix, lcd_rstn, disp, backlight, ready
      case (m_phase)
         4:       o = 5'b01100;
         5:       o = {3'b111, (m_t >= BL), 1'b1};
         6:       o = 5'b11100;
         default: o = 5'b00000;
      endcase
      return {m_phase[2:0], o, m_llc[7:0]};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {state, pix_rstn, lcd_rstn, lcd_disp, backlight, ready, lock_loss_count};
   endfunction

   task automatic model_edge();
      bit ls;
      int nxt;
      ls  = m_ls_b;
      nxt = m_phase;
      if (!resetn) begin
         m_phase = 0; m_t = 0; m_llc = 0; m_ls_a = 1'b0; m_ls_b = 1'b0;
      end else begin
         case (m_phase)
            0: if (enable) nxt = 1;
            1: if (!enable) nxt = 0; else if (ls) nxt = 2;
            2, 3, 4: begin
               if (!ls) nxt = 1;
               else if (!enable) nxt = 0;
               else if (m_t + 1 >= dur(m_phase)) nxt = m_phase + 1;
            end
            5: begin
               if (!ls) begin
                  nxt = 1;
                  if (m_llc < 255) m_llc = m_llc + 1;
               end else if (!enable) nxt = 6;
            end
            6: if (!ls || (m_t + 1 >= OD)) nxt = 0;
            default: nxt = 0;
         endcase
         if (nxt != m_phase) m_t = 0;
         else                m_t = m_t + 1;
         m_phase = nxt;
         m_ls_b  = m_ls_a;
         m_ls_a  = locked;
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      checks = checks + 1;
      if (dut_vec() !== model_vec()) begin
         errors = errors + 1;
         $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, dut_vec(), model_vec());
      end
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic wait_phase(input int p, input int max);
      for (int i = 0; i < max && m_phase != p; i++) step();
      checks = checks + 1;
      if (m_phase != p || state !== p[2:0]) begin
         errors = errors + 1;
         $display("FAIL wait_state got=%0d expected=%0d", state, p);
      end
   endtask

   initial begin
      resetn = 1'b0; locked = 1'b0; enable = 1'b0;
      step(); step();
      check("reset_state", dut_vec(), 16'h0000);

      // Nominal bring-up.
      resetn = 1'b1; locked = 1'b1;
      step(); step(); step();
      enable = 1'b1;
      step();
      check("e0_state", {13'd0, state}, 16'd1);
      for (int k = 1; k <= 22; k++) begin
         step();
         if (k == 1)  check("e1_settle", {13'd0, state}, 16'd2);
         if (k == 8)  check("settle_end", {13'd0, state}, 16'd2);
         if (k == 9)  check("prst_entry", {13'd0, state}, 16'd3);
         if (k == 12) check("disp_before", {14'd0, lcd_rstn, lcd_disp}, 16'd0);
         if (k == 13) check("disp_rise", {11'd0, state, lcd_rstn, lcd_disp}, {11'd0, 3'd4, 2'b11});
         if (k == 15) check("ready_before", {14'd0, ready, pix_rstn}, 16'd0);
         if (k == 16) check("ready_rise", {11'd0, state, ready, pix_rstn}, {11'd0, 3'd5, 2'b11});
         if (k == 20) check("bl_before", {15'd0, backlight}, 16'd0);
         if (k == 21) check("bl_rise", {15'd0, backlight}, 16'd1);
      end

      // Orderly shutdown from RUN with backlight on.
      enable = 1'b0;
      step();
      check("pd_bl_off", {12'd0, state, backlight}, {12'd0, 3'd6, 1'b0});
      step();
      check("pd_hold", {12'd0, state, lcd_disp}, {12'd0, 3'd6, 1'b1});
      step();
      check("pd_off", {12'd0, state, lcd_disp}, {12'd0, 3'd0, 1'b0});

      // Lock glitch during SETTLE.
      enable = 1'b1;
      wait_phase(2, 20);
      step(); step(); step(); step();
      locked = 1'b0;
      step(); step(); step();
      check("glitch_wait", {5'd0, state, lock_loss_count}, {5'd0, 3'd1, 8'd0});
      locked = 1'b1;
      wait_phase(2, 10);
      for (int k = 0; k < LS - 1; k++) step();
      check("resettle_hold", {13'd0, state}, 16'd2);
      step();
      check("resettle_done", {13'd0, state}, 16'd3);

      // Lock loss in RUN, then repeated losses to saturation.
      wait_phase(5, 40);
      locked = 1'b0;
      step(); step(); step();
      check("loss_run", dut_vec(), {3'd1, 5'b00000, 8'd1});
      for (int i = 0; i < 299; i++) begin
         locked = 1'b1;
         wait_phase(5, 40);
         locked = 1'b0;
         step(); step(); step();
      end
      check("loss_saturate", dut_vec(), {3'd1, 5'b00000, 8'd255});

      // Disable during panel reset.
      locked = 1'b1;
      wait_phase(3, 40);
      enable = 1'b0;
      step();
      check("disable_prst", dut_vec(), 16'h00FF);

      // Reset while running.
      enable = 1'b1;
      wait_phase(5, 40);
      step(); step();
      resetn = 1'b0;
      step();
      check("reset_run", dut_vec(), 16'h0000);
      resetn = 1'b1;

      // Random stimulus against the model.
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 999) < 15) locked = ~locked;
         if ($urandom_range(0, 999) < 12) enable = ~enable;
         resetn = ($urandom_range(0, 999) >= 3);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
